// File: rtl/fm_demod_pkg.sv
// Shared definitions for the FM quadrature discriminator: CORDIC arctangent table,
// half-turn phase constant and the sequencing states of the vectoring engine.
package fm_demod_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ROT  = 2'd1,
        ST_OUT  = 2'd2
    } fm_state_e;

    localparam int LUT_WIDTH = 16;
    localparam int LUT_DEPTH = 16;

    // round(atan(2^-k) * 2^16 / (2*pi)); a full turn is 2^16
    localparam logic [LUT_WIDTH-1:0] ATAN_LUT [LUT_DEPTH] = '{
        16'd8192, 16'd4836, 16'd2555, 16'd1297, 16'd651, 16'd326, 16'd163, 16'd81,
        16'd41,   16'd20,   16'd10,   16'd5,    16'd3,   16'd1,   16'd1,   16'd0
    };

    localparam logic [LUT_WIDTH-1:0] PI_PHASE = 16'h8000;

    // Table entry k at a 2^width full-turn scale; wider phases are evaluated at elaboration
    function automatic int atan_entry(input int k, input int width);
        real x;
        real term;
        real acc;
        if (width <= LUT_WIDTH) begin
            return int'(ATAN_LUT[k]) >> (LUT_WIDTH - width);
        end
        if (k == 0) begin
            return 1 << (width - 3);
        end
        x    = 1.0 / (2.0 ** real'(k));
        term = x;
        acc  = 0.0;
        for (int n = 0; n < 40; n++) begin
            acc  = (n % 2 == 0) ? acc + term / real'(2 * n + 1) : acc - term / real'(2 * n + 1);
            term = term * x * x;
        end
        return $rtoi(acc * (2.0 ** real'(width)) / (2.0 * 3.14159265358979) + 0.5);
    endfunction

endpackage

// File: rtl/fm_cordic_atan2.sv
// Iterative CORDIC vectoring engine: one micro-rotation per clock, returns the phase
// of the captured I/Q pair with a full turn mapped onto 2^DATA_WIDTH.
module fm_cordic_atan2
    import fm_demod_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ITER       = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         i_start,
    input  logic signed [DATA_WIDTH-1:0] i_i,
    input  logic signed [DATA_WIDTH-1:0] i_q,
    output logic                         o_busy,
    output logic                         o_done,
    output logic        [DATA_WIDTH-1:0] o_phase
);

    // Two guard bits absorb the negation of the most negative input and the CORDIC gain
    localparam int XW = DATA_WIDTH + 2;
    localparam int KW = (ITER > 1) ? $clog2(ITER) : 1;
    localparam logic [KW-1:0]         K_LAST = KW'(ITER - 1);
    localparam logic [DATA_WIDTH-1:0] PI_Z   = DATA_WIDTH'((64'(PI_PHASE) << DATA_WIDTH) >> LUT_WIDTH);

    fm_state_e             r_state;
    logic signed [XW-1:0]  r_x;
    logic signed [XW-1:0]  r_y;
    logic [DATA_WIDTH-1:0] r_z;
    logic [KW-1:0]         r_k;

    logic signed [XW-1:0]  w_i_ext;
    logic signed [XW-1:0]  w_q_ext;
    logic signed [XW-1:0]  w_x_sh;
    logic signed [XW-1:0]  w_y_sh;
    logic [DATA_WIDTH-1:0] w_atan [ITER];
    logic [DATA_WIDTH-1:0] w_atan_k;
    logic                  w_y_neg;

    for (genvar g = 0; g < ITER; g++) begin : g_atan
        localparam logic [DATA_WIDTH-1:0] ATAN_G = DATA_WIDTH'(atan_entry(g, DATA_WIDTH));
        assign w_atan[g] = ATAN_G;
    end

    assign w_i_ext  = XW'(i_i);
    assign w_q_ext  = XW'(i_q);
    assign w_x_sh   = r_x >>> r_k;
    assign w_y_sh   = r_y >>> r_k;
    assign w_atan_k = w_atan[r_k];
    assign w_y_neg  = r_y[XW-1];

    assign o_busy  = (r_state != ST_IDLE);
    assign o_done  = (r_state == ST_OUT);
    assign o_phase = r_z;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_x     <= '0;
            r_y     <= '0;
            r_z     <= '0;
            r_k     <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        if (i_i[DATA_WIDTH-1]) begin
                            r_x <= -w_i_ext;
                            r_y <= -w_q_ext;
                            r_z <= PI_Z;
                        end else begin
                            r_x <= w_i_ext;
                            r_y <= w_q_ext;
                            r_z <= '0;
                        end
                        r_k     <= '0;
                        r_state <= ST_ROT;
                    end
                end
                ST_ROT: begin
                    // NOTE: non-blocking updates make x and y both rotate from their pre-edge values.
                    if (!w_y_neg) begin
                        r_x <= r_x + w_y_sh;
                        r_y <= r_y - w_x_sh;
                        r_z <= r_z + w_atan_k;
                    end else begin
                        r_x <= r_x - w_y_sh;
                        r_y <= r_y + w_x_sh;
                        r_z <= r_z - w_atan_k;
                    end
                    r_k <= r_k + KW'(1);
                    if (r_k == K_LAST) begin
                        r_state <= ST_OUT;
                    end
                end
                ST_OUT:  r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/fm_quad_discriminator.sv
// FM quadrature discriminator: phase of each I/Q sample via CORDIC, output is the
// wrapped phase step between consecutive samples on an Avalon-ST style source.
module fm_quad_discriminator #(
    parameter int DATA_WIDTH = 16,
    parameter int ITER       = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic signed [DATA_WIDTH-1:0] ast_sink_data_i,
    input  logic signed [DATA_WIDTH-1:0] ast_sink_data_q,
    input  logic                         ast_sink_valid,
    input  logic        [1:0]            ast_sink_error,
    output logic signed [DATA_WIDTH-1:0] ast_source_data,
    output logic                         ast_source_valid,
    output logic        [1:0]            ast_source_error,
    output logic                         overrun
);

    logic                  w_busy;
    logic                  w_done;
    logic                  w_accept;
    logic [DATA_WIDTH-1:0] w_phase;
    logic [DATA_WIDTH-1:0] w_z;

    logic [DATA_WIDTH-1:0] r_prev_phase;
    logic                  r_primed;
    logic                  r_zero;
    logic [1:0]            r_err;

    assign w_accept = ast_sink_valid && !w_busy;

    fm_cordic_atan2 #(
        .DATA_WIDTH (DATA_WIDTH),
        .ITER       (ITER)
    ) u_cordic (
        .clk     (clk),
        .reset   (reset),
        .i_start (w_accept),
        .i_i     (ast_sink_data_i),
        .i_q     (ast_sink_data_q),
        .o_busy  (w_busy),
        .o_done  (w_done),
        .o_phase (w_phase)
    );

    // A zero vector has no angle; holding the previous phase yields a zero step
    assign w_z = r_zero ? r_prev_phase : w_phase;

    always_ff @(posedge clk) begin
        if (reset) begin
            ast_source_data  <= '0;
            ast_source_valid <= 1'b0;
            ast_source_error <= 2'b00;
            overrun          <= 1'b0;
            r_prev_phase     <= '0;
            r_primed         <= 1'b0;
            r_zero           <= 1'b0;
            r_err            <= 2'b00;
        end else begin
            ast_source_valid <= 1'b0;
            if (ast_sink_valid) begin
                if (w_busy) begin
                    overrun <= 1'b1;
                end else begin
                    r_err  <= ast_sink_error;
                    r_zero <= (ast_sink_data_i == '0) && (ast_sink_data_q == '0);
                end
            end
            if (w_done) begin
                if (r_primed) begin
                    ast_source_data  <= w_z - r_prev_phase;
                    ast_source_valid <= 1'b1;
                    ast_source_error <= r_err;
                end
                r_prev_phase <= w_z;
                r_primed     <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fm_quad_discriminator.sv
// Scoreboard bench: an atan2-based reference predicts each phase step when a sample is
// issued; a negedge monitor pops and compares on every output strobe.
module tb_fm_quad_discriminator;

    localparam int  DW      = 16;
    localparam int  ITER    = 16;
    localparam int  SPACING = 24;
    localparam int  LAT     = ITER + 1;
    localparam int  TOL     = 6;
    localparam real PI      = 3.14159265358979;

    typedef struct {
        int         data;
        logic [1:0] err;
        int         cyc;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic signed [DW-1:0] s_i = '0;
    logic signed [DW-1:0] s_q = '0;
    logic                 s_valid = 1'b0;
    logic [1:0]           s_err = 2'b00;
    logic signed [DW-1:0] o_data;
    logic                 o_valid;
    logic [1:0]           o_err;
    logic                 o_ovr;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   m_prev = 0;
    bit   m_primed = 1'b0;
    int   m_next_ok = 0;
    bit   m_overrun = 1'b0;

    fm_quad_discriminator #(.DATA_WIDTH(DW), .ITER(ITER)) dut (
        .clk              (clk),
        .reset            (reset),
        .ast_sink_data_i  (s_i),
        .ast_sink_data_q  (s_q),
        .ast_sink_valid   (s_valid),
        .ast_sink_error   (s_err),
        .ast_source_data  (o_data),
        .ast_source_valid (o_valid),
        .ast_source_error (o_err),
        .overrun          (o_ovr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input bit ok, input string detail);
        n_cmp++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: %s", name, detail);
        end
    endtask

    function automatic int wrap(input int v);
        logic [DW-1:0] t;
        t = DW'(v);
        return int'(signed'(t));
    endfunction

    // Ideal phase of (i,q) with a full turn = 2^DW, in [0, 2^DW)
    function automatic int ref_phase(input int i, input int q);
        real a;
        a = $atan2(real'(q), real'(i));
        return int'(a * real'(1 << DW) / (2.0 * PI)) & ((1 << DW) - 1);
    endfunction

    task automatic issue(input int i, input int q, input logic [1:0] err, input int gap);
        int   c;
        int   ph;
        exp_t e;
        @(negedge clk);
        s_i     = DW'(i);
        s_q     = DW'(q);
        s_err   = err;
        s_valid = 1'b1;
        c = cyc + 1;
        if (c >= m_next_ok) begin
            m_next_ok = c + ITER + 2;
            ph = (i == 0 && q == 0) ? m_prev : ref_phase(i, q);
            if (m_primed) begin
                e.data = wrap(ph - m_prev);
                e.err  = err;
                e.cyc  = c + LAT;
                sb.push_back(e);
            end
            m_prev   = ph;
            m_primed = 1'b1;
        end else begin
            m_overrun = 1'b1;
        end
        @(negedge clk);
        s_valid = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic issue_polar(input real amp, input real ang, input logic [1:0] err, input int gap);
        issue(int'(amp * $cos(ang)), int'(amp * $sin(ang)), err, gap);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_data"},  o_data == '0, $sformatf("data got %0d want 0", o_data));
        check({tag, "_valid"}, o_valid == 1'b0, $sformatf("valid got %0b want 0", o_valid));
        check({tag, "_error"}, o_err == 2'b00, $sformatf("error got %0d want 0", o_err));
        check({tag, "_overrun"}, o_ovr == 1'b0, $sformatf("overrun got %0b want 0", o_ovr));
    endtask

    task automatic apply_reset(input int cycles);
        @(negedge clk);
        reset   = 1'b1;
        s_valid = 1'b0;
        sb.delete();
        m_prev    = 0;
        m_primed  = 1'b0;
        m_next_ok = 0;
        m_overrun = 1'b0;
        repeat (cycles) @(negedge clk);
        check_idle_outputs("reset");
        reset = 1'b0;
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (!reset && o_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_strobe", 1'b0, $sformatf("strobe data=%0d at cycle %0d, none pending", o_data, cyc));
            end else begin
                e = sb.pop_front();
                check("phase_step", wrap(int'(o_data) - e.data) <= TOL && wrap(int'(o_data) - e.data) >= -TOL,
                      $sformatf("got %0d want %0d +/-%0d", o_data, e.data, TOL));
                check("strobe_error", o_err == e.err, $sformatf("got %0d want %0d", o_err, e.err));
                check("strobe_cycle", cyc == e.cyc, $sformatf("got cycle %0d want %0d", cyc, e.cyc));
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish within the time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int spacing;
        real amp;
        real ang;
        repeat (3) @(negedge clk);
        check_idle_outputs("power_on");
        reset = 1'b0;

        // Constant +pi/4 steps; first sample only primes
        for (int k = 0; k < 16; k++) issue_polar(16000.0, real'(k) * PI / 4.0, 2'b00, SPACING - 2);
        check("overrun_clean", o_ovr == m_overrun, $sformatf("got %0b want %0b", o_ovr, m_overrun));

        // Constant -pi/8 steps
        for (int k = 0; k < 17; k++) issue_polar(12000.0, -real'(k) * PI / 8.0, 2'b00, SPACING - 2);

        // Wrap across +/-pi, and extreme axis samples
        issue_polar(16000.0, 3.0 * PI / 4.0, 2'b00, SPACING - 2);
        issue_polar(16000.0, -3.0 * PI / 4.0, 2'b00, SPACING - 2);
        issue(-32768, 0, 2'b00, SPACING - 2);
        issue(0, 32767, 2'b00, SPACING - 2);

        // Second sample 5 clocks after the first is dropped
        issue_polar(10000.0, PI / 3.0, 2'b00, 3);
        issue_polar(10000.0, -PI / 2.0, 2'b00, SPACING - 2);
        check("overrun_set", o_ovr == 1'b1, $sformatf("got %0b want 1", o_ovr));
        issue_polar(10000.0, PI / 2.0, 2'b00, SPACING - 2);

        // Zero vector and error propagation
        issue(0, 0, 2'b00, SPACING - 2);
        issue_polar(14000.0, 1.0, 2'b10, SPACING - 2);
        issue_polar(14000.0, 2.2, 2'b00, SPACING - 2);
        issue(0, 0, 2'b10, SPACING - 2);
        issue_polar(14000.0, -0.7, 2'b01, SPACING - 2);

        // Randomized samples, spacing straddling the minimum of ITER+2
        for (int n = 0; n < 20; n++) begin
            spacing = int'($urandom_range(ITER + 6, ITER));
            amp     = real'($urandom_range(30000, 12000));
            ang     = real'($urandom_range(65535, 0)) * 2.0 * PI / 65536.0;
            if ($urandom_range(7, 0) == 0) issue(0, 0, 2'($urandom_range(3, 0)), spacing - 2);
            else issue_polar(amp, ang, 2'($urandom_range(3, 0)), spacing - 2);
        end
        repeat (SPACING) @(negedge clk);
        check("overrun_sticky", o_ovr == m_overrun, $sformatf("got %0b want %0b", o_ovr, m_overrun));

        // Reset five rotations into a calculation aborts it
        issue_polar(15000.0, 0.3, 2'b11, 4);
        apply_reset(1);
        issue_polar(15000.0, 0.5, 2'b00, SPACING - 2);
        issue_polar(15000.0, 1.5, 2'b01, SPACING - 2);

        for (int w = 0; w < 3 * LAT && sb.size() != 0; w++) @(negedge clk);
        repeat (SPACING) @(negedge clk);
        check("drain", sb.size() == 0, $sformatf("%0d outputs still pending, want 0", sb.size()));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
